// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: serial line, consumer handshake and status signals of the UART receiver.
interface uart_rx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 rxd;
    logic                 data_ready;
    logic                 clr_overrun;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 break_det;
    logic                 overrun;
    logic                 busy;
    modport master (
        output rxd, data_ready, clr_overrun,
        input  data_out, data_valid, parity_err, frame_err, break_det, overrun, busy
    );
    modport slave (
        input  rxd, data_ready, clr_overrun,
        output data_out, data_valid, parity_err, frame_err, break_det, overrun, busy
    );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: x16-oversampled UART receiver with 3-sample majority vote, false-start rejection,
// parity/framing/break/overrun reporting and a valid/ready holding register.
module uart_rx_param #(
    parameter int CLK_FREQ  = 25000000,
    parameter int BAUD      = 9600,
    parameter int ACC_WIDTH = 17,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input logic          clk,
    input logic          reset,
    uart_rx_param_if.slave bus
);
    localparam longint INC_L = (longint'(BAUD) * 16 * (longint'(1) << ACC_WIDTH) + longint'(CLK_FREQ) / 2)
                               / longint'(CLK_FREQ);
    localparam logic [ACC_WIDTH:0] INC = (ACC_WIDTH + 1)'(INC_L);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY_BIT, STOP} state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, rxs_q;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 tick, maj, mid, done, frame_fe, frame_brk;
    logic [3:0]           phase_q, phase_d, bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d, s0_q, s0_d, s1_q, s1_d;
    logic                 stop0_q, stop0_d, par_bit_q, par_bit_d;
    logic                 pe_acc_q, pe_acc_d, fe_acc_q, fe_acc_d, brk_wait_q, brk_wait_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, brk_q, brk_d, ovr_q, ovr_d;

    assign {tick, acc_d} = {1'b0, acc_q} + INC;
    assign maj = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
    assign mid = tick && phase_q == 4'd9;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        s0_d       = s0_q;
        s1_d       = s1_q;
        stop0_d    = stop0_q;
        par_bit_d  = par_bit_q;
        pe_acc_d   = pe_acc_q;
        fe_acc_d   = fe_acc_q;
        shift_d    = shift_q;
        brk_wait_d = brk_wait_q;
        done       = 1'b0;
        frame_fe   = fe_acc_q | ~maj;
        frame_brk  = shift_q == '0 && (PARITY == 0 || !par_bit_q) && !(stop_cnt_q == 1'b0 ? maj : stop0_q);
        if (tick && state_q != IDLE) begin
            phase_d = phase_q + 4'd1;
            s0_d    = phase_q == 4'd7 ? rxs_q : s0_q;
            s1_d    = phase_q == 4'd8 ? rxs_q : s1_q;
        end
        case (state_q)
            IDLE: begin
                // after a break the line must be seen high on a tick before a new start counts
                brk_wait_d = brk_wait_q && !(tick && rxs_q);
                if (tick && !rxs_q && !brk_wait_q) begin
                    state_d    = START;
                    phase_d    = '0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    pe_acc_d   = 1'b0;
                    fe_acc_d   = 1'b0;
                end
            end
            START: begin
                if (mid && maj) state_d = IDLE;
                else if (tick && phase_q == 4'd15) state_d = DATA;
            end
            DATA: begin
                if (mid) begin
                    shift_d   = {maj, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (tick && phase_q == 4'd15 && bit_cnt_q == 4'(DATA_BITS))
                    state_d = (PARITY == 0) ? STOP : PARITY_BIT;
            end
            PARITY_BIT: begin
                if (mid) begin
                    par_bit_d = maj;
                    pe_acc_d  = maj ^ (^shift_q) ^ (PARITY == 2);
                end
                if (tick && phase_q == 4'd15) state_d = STOP;
            end
            STOP: begin
                if (mid) begin
                    fe_acc_d   = frame_fe;
                    stop0_d    = stop_cnt_q == 1'b0 ? maj : stop0_q;
                    stop_cnt_d = stop_cnt_q + 1'b1;
                    // finish at mid-stop so a start edge in the remaining half bit is still caught
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        done       = 1'b1;
                        state_d    = IDLE;
                        brk_wait_d = frame_brk;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        valid_d = valid_q;
        ovr_d   = ovr_q & ~bus.clr_overrun;
        brk_d   = done & frame_brk;
        if (done && (!valid_q || bus.data_ready)) begin
            data_d  = shift_q;
            pe_d    = pe_acc_q;
            fe_d    = frame_fe;
            valid_d = 1'b1;
        end else if (done) begin
            ovr_d = 1'b1;
        end else if (valid_q && bus.data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            acc_q      <= '0;
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            stop0_q    <= 1'b1;
            par_bit_q  <= 1'b0;
            pe_acc_q   <= 1'b0;
            fe_acc_q   <= 1'b0;
            brk_wait_q <= 1'b0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            brk_q      <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            sync1_q    <= bus.rxd;
            rxs_q      <= sync1_q;
            acc_q      <= acc_d;
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            stop0_q    <= stop0_d;
            par_bit_q  <= par_bit_d;
            pe_acc_q   <= pe_acc_d;
            fe_acc_q   <= fe_acc_d;
            brk_wait_q <= brk_wait_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            brk_q      <= brk_d;
            ovr_q      <= ovr_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.parity_err = pe_q;
    assign bus.frame_err  = fe_q;
    assign bus.break_det  = brk_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: vector table over 8N1, 7E1 and 8N2 receivers plus hand sequences for
// glitch, overrun, break and mid-frame reset. Tick = 4 clk, so one bit = 64 clk.
module tb_uart_rx_param;
    localparam int BIT_CLK = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] rxd_v = 3'b111;
    logic [2:0] ready_v = 3'b000;
    logic [2:0] clr_v = 3'b000;
    int         checks = 0;
    int         errors = 0;
    int         cons [3] = '{0, 0, 0};
    logic [8:0] cap_d [3];
    logic       cap_pe [3];
    logic       cap_fe [3];
    int         brk_a = 0;

    typedef struct {
        int         d;
        logic [8:0] data;
        logic       pflip;
        logic [1:0] stops;
        logic [8:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;
    vec_t vecs [8];

    uart_rx_param_if #(.DATA_BITS(8)) ifa ();
    uart_rx_param_if #(.DATA_BITS(7)) ifb ();
    uart_rx_param_if #(.DATA_BITS(8)) ifc ();

    assign ifa.rxd = rxd_v[0];
    assign ifb.rxd = rxd_v[1];
    assign ifc.rxd = rxd_v[2];
    assign ifa.data_ready = ready_v[0];
    assign ifb.data_ready = ready_v[1];
    assign ifc.data_ready = ready_v[2];
    assign ifa.clr_overrun = clr_v[0];
    assign ifb.clr_overrun = clr_v[1];
    assign ifc.clr_overrun = clr_v[2];

    uart_rx_param #(.CLK_FREQ(6400000), .BAUD(100000), .ACC_WIDTH(17), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
    uart_rx_param #(.CLK_FREQ(6400000), .BAUD(100000), .ACC_WIDTH(17), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1))
        dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
    uart_rx_param #(.CLK_FREQ(6400000), .BAUD(100000), .ACC_WIDTH(17), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2))
        dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifa.data_valid && ifa.data_ready) begin
            cons[0]++;
            cap_d[0] = 9'(ifa.data_out);
            cap_pe[0] = ifa.parity_err;
            cap_fe[0] = ifa.frame_err;
        end
        if (ifb.data_valid && ifb.data_ready) begin
            cons[1]++;
            cap_d[1] = 9'(ifb.data_out);
            cap_pe[1] = ifb.parity_err;
            cap_fe[1] = ifb.frame_err;
        end
        if (ifc.data_valid && ifc.data_ready) begin
            cons[2]++;
            cap_d[2] = 9'(ifc.data_out);
            cap_pe[2] = ifc.parity_err;
            cap_fe[2] = ifc.frame_err;
        end
        if (ifa.break_det) brk_a++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // d selects the receiver: 0 = 8N1, 1 = 7E1, 2 = 8N2
    task automatic send_frame(input int d, input logic [8:0] data, input logic pflip, input logic [1:0] stops);
        logic [15:0] f;
        logic        p;
        int          n;
        int          nd;
        nd = (d == 1) ? 7 : 8;
        f = '0;
        n = 1;
        p = 1'b0;
        for (int i = 0; i < nd; i++) begin
            f[n] = data[i];
            p = p ^ data[i];
            n++;
        end
        if (d == 1) begin
            f[n] = p ^ pflip;
            n++;
        end
        for (int i = 0; i < ((d == 2) ? 2 : 1); i++) begin
            f[n] = stops[i];
            n++;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rxd_v[d] = f[i];
            repeat (BIT_CLK - 1) @(negedge clk);
        end
        @(negedge clk);
        rxd_v[d] = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        int c0;
        int b0;
        int n;
        int t;
        vecs[0] = '{0, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h0A3, 1'b0, 2'b11, 9'h0A3, 1'b0, 1'b0};
        vecs[2] = '{0, 9'h081, 1'b0, 2'b00, 9'h081, 1'b0, 1'b1};
        vecs[3] = '{1, 9'h041, 1'b0, 2'b11, 9'h041, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h041, 1'b1, 2'b11, 9'h041, 1'b1, 1'b0};
        vecs[5] = '{1, 9'h07F, 1'b0, 2'b11, 9'h07F, 1'b0, 1'b0};
        vecs[6] = '{2, 9'h03C, 1'b0, 2'b11, 9'h03C, 1'b0, 1'b0};
        vecs[7] = '{2, 9'h0C5, 1'b0, 2'b01, 9'h0C5, 1'b0, 1'b1};

        #1 reset = 1'b1;
        #1;
        check("rst_valid", int'(ifa.data_valid), 0);
        check("rst_data", int'(ifa.data_out), 0);
        check("rst_busy", int'(ifa.busy), 0);
        check("rst_overrun", int'(ifa.overrun), 0);
        check("rst_errs", int'({ifa.parity_err, ifa.frame_err, ifa.break_det}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        ready_v = 3'b111;
        for (int i = 0; i < 8; i++) begin
            c0 = cons[vecs[i].d];
            send_frame(vecs[i].d, vecs[i].data, vecs[i].pflip, vecs[i].stops);
            repeat (2 * BIT_CLK) @(negedge clk);
            check($sformatf("vec%0d_count", i), cons[vecs[i].d] - c0, 1);
            check($sformatf("vec%0d_data", i), int'(cap_d[vecs[i].d]), int'(vecs[i].exp_d));
            check($sformatf("vec%0d_perr", i), int'(cap_pe[vecs[i].d]), int'(vecs[i].exp_pe));
            check($sformatf("vec%0d_ferr", i), int'(cap_fe[vecs[i].d]), int'(vecs[i].exp_fe));
        end

        c0 = cons[0];
        fork
            begin
                @(negedge clk);
                rxd_v[0] = 1'b0;
                repeat (12) @(negedge clk);
                rxd_v[0] = 1'b1;
            end
            begin
                t = 0;
                while (!ifa.busy && t < 40) begin
                    @(negedge clk);
                    t++;
                end
                n = 0;
                while (ifa.busy && n < 200) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        check("glitch_busy_rise", int'(t < 40), 1);
        check("glitch_busy_len", n, 40);
        repeat (2 * BIT_CLK) @(negedge clk);
        check("glitch_no_word", cons[0] - c0, 0);

        ready_v[0] = 1'b0;
        fork
            send_frame(0, 9'h012, 1'b0, 2'b11);
            begin
                t = 0;
                while (!ifa.busy && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                n = 0;
                while (ifa.busy && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
            end
        join
        check("frame_busy_len", n, 616);
        repeat (BIT_CLK) @(negedge clk);
        send_frame(0, 9'h034, 1'b0, 2'b11);
        repeat (BIT_CLK) @(negedge clk);
        check("ovr_data", int'(ifa.data_out), 'h12);
        check("ovr_valid", int'(ifa.data_valid), 1);
        check("ovr_flag", int'(ifa.overrun), 1);
        @(negedge clk);
        ready_v[0] = 1'b1;
        clr_v[0] = 1'b1;
        @(negedge clk);
        ready_v[0] = 1'b0;
        clr_v[0] = 1'b0;
        @(negedge clk);
        check("clr_valid", int'(ifa.data_valid), 0);
        check("clr_overrun", int'(ifa.overrun), 0);

        send_frame(0, 9'h012, 1'b0, 2'b11);
        repeat (BIT_CLK) @(negedge clk);
        check("hold_data", int'(ifa.data_out), 'h12);
        fork
            send_frame(0, 9'h034, 1'b0, 2'b11);
            begin
                t = 0;
                while (!ifa.busy && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                repeat (615) @(negedge clk);
                ready_v[0] = 1'b1;
                @(negedge clk);
                ready_v[0] = 1'b0;
            end
        join
        repeat (BIT_CLK) @(negedge clk);
        check("swap_data", int'(ifa.data_out), 'h34);
        check("swap_valid", int'(ifa.data_valid), 1);
        check("swap_overrun", int'(ifa.overrun), 0);

        @(negedge clk);
        ready_v[0] = 1'b1;
        @(negedge clk);
        ready_v[0] = 1'b0;
        b0 = brk_a;
        rxd_v[0] = 1'b0;
        repeat (11 * BIT_CLK) @(negedge clk);
        check("brk_idle_hold", int'(ifa.busy), 0);
        repeat (BIT_CLK) @(negedge clk);
        rxd_v[0] = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("brk_pulses", brk_a - b0, 1);
        check("brk_data", int'(ifa.data_out), 0);
        check("brk_ferr", int'(ifa.frame_err), 1);
        check("brk_valid", int'(ifa.data_valid), 1);
        ready_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        c0 = cons[0];
        send_frame(0, 9'h07E, 1'b0, 2'b11);
        repeat (2 * BIT_CLK) @(negedge clk);
        check("post_brk_count", cons[0] - c0, 1);
        check("post_brk_data", int'(cap_d[0]), 'h7E);
        check("post_brk_ferr", int'(cap_fe[0]), 0);

        ready_v[0] = 1'b0;
        send_frame(0, 9'h00F, 1'b0, 2'b11);
        repeat (BIT_CLK) @(negedge clk);
        send_frame(0, 9'h00F, 1'b0, 2'b11);
        repeat (BIT_CLK) @(negedge clk);
        check("pre_rst_overrun", int'(ifa.overrun), 1);
        check("pre_rst_valid", int'(ifa.data_valid), 1);
        fork
            send_frame(0, 9'h0C3, 1'b0, 2'b11);
            begin
                repeat (4 * BIT_CLK) @(negedge clk);
                check("mid_rst_busy_before", int'(ifa.busy), 1);
                #3 reset = 1'b1;
                #1;
                check("mid_rst_valid", int'(ifa.data_valid), 0);
                check("mid_rst_data", int'(ifa.data_out), 0);
                check("mid_rst_overrun", int'(ifa.overrun), 0);
                check("mid_rst_busy", int'(ifa.busy), 0);
            end
        join
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * BIT_CLK) @(negedge clk);
        check("post_rst_valid", int'(ifa.data_valid), 0);
        ready_v[0] = 1'b1;
        repeat (2) @(negedge clk);
        c0 = cons[0];
        send_frame(0, 9'h05A, 1'b0, 2'b11);
        repeat (2 * BIT_CLK) @(negedge clk);
        check("post_rst_count", cons[0] - c0, 1);
        check("post_rst_data", int'(cap_d[0]), 'h5A);
        check("post_rst_errs", int'({cap_pe[0], cap_fe[0]}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
